// File: rtl/prio_sel_pipe.sv
// prio_sel_pipe: bitwise A/B select plus priority encode, queued in a DEPTH-entry output FIFO.
// Build option: define PRIO_SEL_ROTATE_EN for round-robin priority from a rotating start lane.
module prio_sel_pipe #(
   parameter int W = 8,
   parameter int DEPTH = 2,
   localparam int IW = $clog2(W),
   localparam int OW = $clog2(DEPTH) + 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [W-1:0]  in_a,
   input  logic [W-1:0]  in_b,
   input  logic          in_sel,
   input  logic [W-1:0]  in_mask,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [W-1:0]  out_vec,
   output logic [W-1:0]  out_grant,
   output logic [IW-1:0] out_idx,
   output logic          out_any,
   output logic [OW-1:0] occupancy
);

   localparam int PW = $clog2(DEPTH);

   logic [W-1:0]  sel_vec_p0;
   logic [W-1:0]  grant_p0;
   logic [IW-1:0] idx_p0;
   logic          any_p0;
   logic [IW-1:0] start_p0;
   logic          push;
   logic          pop;
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;

   logic [W-1:0]  vec_mem   [DEPTH];
   logic [W-1:0]  grant_mem [DEPTH];
   logic [IW-1:0] idx_mem   [DEPTH];
   logic          any_mem   [DEPTH];

   // Stage 0: select, mask and priority search starting at start_p0
   assign sel_vec_p0 = (in_sel ? in_b : in_a) & in_mask;

   always_comb begin
      int            lane;
      logic [IW-1:0] lane_i;
      grant_p0 = '0;
      idx_p0   = '0;
      any_p0   = 1'b0;
      lane     = 0;
      lane_i   = '0;
      // Walk the search order backwards so the earliest lane in order is the last hit kept
      for (int k = W - 1; k >= 0; k--) begin
         lane = k + int'(start_p0);
         if (lane >= W) lane = lane - W;
         lane_i = IW'(lane);
         if (sel_vec_p0[lane_i]) begin
            grant_p0         = '0;
            grant_p0[lane_i] = 1'b1;
            idx_p0           = lane_i;
            any_p0           = 1'b1;
         end
      end
   end

   assign out_valid = (occupancy != '0);
   assign pop       = out_valid & out_ready;
   assign in_ready  = (occupancy < OW'(DEPTH)) | pop;
   assign push      = in_valid & in_ready;

`ifdef PRIO_SEL_ROTATE_EN
   logic [IW-1:0] rp;

   always_ff @(posedge clk) begin
      if (rst) begin
         rp <= '0;
      end else if (push && any_p0) begin
         rp <= (idx_p0 == IW'(W - 1)) ? '0 : idx_p0 + 1'b1;
      end
   end

   assign start_p0 = rp;
`else
   assign start_p0 = '0;
`endif

   // Stage 1: FIFO storage, written at the tail on every accepted beat
   always_ff @(posedge clk) begin
      if (push) begin
         vec_mem[wr_ptr]   <= sel_vec_p0;
         grant_mem[wr_ptr] <= grant_p0;
         idx_mem[wr_ptr]   <= idx_p0;
         any_mem[wr_ptr]   <= any_p0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         occupancy <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         if (push && !pop)      occupancy <= occupancy + 1'b1;
         else if (!push && pop) occupancy <= occupancy - 1'b1;
      end
   end

   // Head data is masked to zero while the FIFO is empty
   assign out_vec   = out_valid ? vec_mem[rd_ptr]   : '0;
   assign out_grant = out_valid ? grant_mem[rd_ptr] : '0;
   assign out_idx   = out_valid ? idx_mem[rd_ptr]   : '0;
   assign out_any   = out_valid ? any_mem[rd_ptr]   : 1'b0;

endmodule

// File: tb/tb_prio_sel_pipe.sv
// Bench for prio_sel_pipe: vector table, FIFO/reset/rotate sequences, and random traffic vs a queue model.
module tb_prio_sel_pipe;
   localparam int W = 8;
   localparam int DEPTH = 2;
   localparam int IW = 3;
   localparam int OW = 2;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  in_a, in_b, in_mask;
   logic          in_sel;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  out_vec, out_grant;
   logic [IW-1:0] out_idx;
   logic          out_any;
   logic [OW-1:0] occupancy;

   int total = 0;
   int bad = 0;

   typedef struct {
      logic          sel;
      logic [W-1:0]  a, b, mask;
      logic [W-1:0]  vec, grant;
      logic [IW-1:0] idx;
      logic          any;
   } vec_t;

   typedef struct {
      logic [W-1:0]  vec, grant;
      logic [IW-1:0] idx;
      logic          any;
   } res_t;

   vec_t tbl[7];
   res_t q[$];
   int   mrp;

   prio_sel_pipe #(.W(W), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_sel(in_sel), .in_mask(in_mask),
      .out_valid(out_valid), .out_ready(out_ready), .out_vec(out_vec),
      .out_grant(out_grant), .out_idx(out_idx), .out_any(out_any),
      .occupancy(occupancy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      step();
      rst = 1'b0;
      mrp = 0;
   endtask

   task automatic drive(input logic sel, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] mask);
      in_sel = sel; in_a = a; in_b = b; in_mask = mask;
   endtask

   // Reference: lowest set bit via two's complement, searching the upper part (>= rp) first
   function automatic res_t model(input logic sel, input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic [W-1:0] mask, input int rp);
      res_t r;
      logic [W-1:0] v, hi, g, ones;
      ones = '1;
      v  = (sel ? b : a) & mask;
      hi = v & (ones << rp);
      g  = (hi != '0) ? (hi & (~hi + 1'b1)) : (v & (~v + 1'b1));
      r.vec = v; r.grant = g; r.any = (v != '0); r.idx = '0;
      for (int i = 0; i < W; i++) if (g[i]) r.idx = IW'(i);
      return r;
   endfunction

   task automatic model_accept(input res_t r);
`ifdef PRIO_SEL_ROTATE_EN
      if (r.any) mrp = (int'(r.idx) + 1) % W;
`endif
   endtask

   initial begin
      logic [W-1:0] exp_rot [6];
      logic [W-1:0] rv_a, rv_b, rv_m;
      logic         rv_sel;
      bit           push, pop, exp_rdy;
      res_t         r;

      tbl[0] = '{1'b1, 8'h00, 8'h30, 8'hFF, 8'h30, 8'h10, 3'd4, 1'b1};
      tbl[1] = '{1'b0, 8'hA0, 8'h55, 8'h7F, 8'h20, 8'h20, 3'd5, 1'b1};
      tbl[2] = '{1'b0, 8'hA0, 8'h55, 8'h00, 8'h00, 8'h00, 3'd0, 1'b0};
      tbl[3] = '{1'b0, 8'hFF, 8'h00, 8'h80, 8'h80, 8'h80, 3'd7, 1'b1};
      tbl[4] = '{1'b1, 8'hFF, 8'h06, 8'hFF, 8'h06, 8'h02, 3'd1, 1'b1};
      tbl[5] = '{1'b0, 8'h0C, 8'hFF, 8'hFF, 8'h0C, 8'h04, 3'd2, 1'b1};
      tbl[6] = '{1'b0, 8'hFF, 8'h00, 8'h01, 8'h01, 8'h01, 3'd0, 1'b1};

      drive(1'b0, '0, '0, '0);
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      step(); step();
      rst = 1'b0;
      #1;
      chk("rst_out_valid", 64'(out_valid), 64'(0));
      chk("rst_occupancy", 64'(occupancy), 64'(0));
      chk("rst_out_vec",   64'(out_vec),   64'(0));
      chk("rst_out_grant", 64'(out_grant), 64'(0));
      chk("rst_out_idx",   64'(out_idx),   64'(0));
      chk("rst_out_any",   64'(out_any),   64'(0));
      chk("rst_in_ready",  64'(in_ready),  64'(1));

      // Table: each vector starts from reset so the start lane is 0 in either build
      for (int i = 0; i < 7; i++) begin
         do_reset();
         drive(tbl[i].sel, tbl[i].a, tbl[i].b, tbl[i].mask);
         in_valid = 1'b1;
         step();
         in_valid = 1'b0;
         chk($sformatf("tbl%0d_valid", i), 64'(out_valid), 64'(1));
         chk($sformatf("tbl%0d_vec", i),   64'(out_vec),   64'(tbl[i].vec));
         chk($sformatf("tbl%0d_grant", i), 64'(out_grant), 64'(tbl[i].grant));
         chk($sformatf("tbl%0d_idx", i),   64'(out_idx),   64'(tbl[i].idx));
         chk($sformatf("tbl%0d_any", i),   64'(out_any),   64'(tbl[i].any));
         out_ready = 1'b1;
         step();
         out_ready = 1'b0;
         chk($sformatf("tbl%0d_drained", i), 64'(out_valid), 64'(0));
         chk($sformatf("tbl%0d_masked", i),  64'(out_vec),   64'(0));
      end

      // Full FIFO: third beat stalls, then same-cycle pop and push keeps occupancy at DEPTH
      do_reset();
      in_valid = 1'b1;
      drive(1'b0, 8'h03, 8'h00, 8'hFF); step();
      chk("full_occ1", 64'(occupancy), 64'(1));
      drive(1'b0, 8'h0C, 8'h00, 8'hFF); step();
      chk("full_occ2", 64'(occupancy), 64'(2));
      drive(1'b0, 8'h30, 8'h00, 8'hFF); #1;
      chk("full_in_ready0", 64'(in_ready), 64'(0));
      step();
      chk("full_stall_occ", 64'(occupancy), 64'(2));
      chk("full_head1", 64'(out_vec), 64'(8'h03));
      out_ready = 1'b1; #1;
      chk("full_in_ready_pop", 64'(in_ready), 64'(1));
      step();
      in_valid = 1'b0;
      chk("full_pushpop_occ", 64'(occupancy), 64'(2));
      chk("full_head2", 64'(out_vec), 64'(8'h0C));
      step();
      chk("full_head3", 64'(out_vec), 64'(8'h30));
      chk("full_occ_drain", 64'(occupancy), 64'(1));
      step();
      chk("full_empty", 64'(out_valid), 64'(0));
      out_ready = 1'b0;

      // Reset with a beat presented: that beat must be discarded
      do_reset();
      drive(1'b0, 8'h40, 8'h00, 8'hFF);
      in_valid = 1'b1; step();
      chk("mid_occ1", 64'(occupancy), 64'(1));
      rst = 1'b1; drive(1'b0, 8'h08, 8'h00, 8'hFF);
      step();
      rst = 1'b0; in_valid = 1'b0; #1;
      chk("mid_valid", 64'(out_valid), 64'(0));
      chk("mid_occ",   64'(occupancy), 64'(0));
      chk("mid_ready", 64'(in_ready),  64'(1));
      step();
      chk("mid_not_stored", 64'(occupancy), 64'(0));
      chk("mid_vec", 64'(out_vec), 64'(0));

      // Rotation sequence: 11 x4, then 00, then 11
`ifdef PRIO_SEL_ROTATE_EN
      exp_rot = '{8'h01, 8'h10, 8'h01, 8'h10, 8'h00, 8'h01};
`else
      exp_rot = '{8'h01, 8'h01, 8'h01, 8'h01, 8'h00, 8'h01};
`endif
      do_reset();
      for (int i = 0; i < 6; i++) begin
         drive(1'b0, (i == 4) ? 8'h00 : 8'h11, 8'h00, 8'hFF);
         in_valid = 1'b1; step(); in_valid = 1'b0;
         chk($sformatf("rot%0d_grant", i), 64'(out_grant), 64'(exp_rot[i]));
         out_ready = 1'b1; step(); out_ready = 1'b0;
      end

      // Random traffic against the queue model
      do_reset();
      q.delete();
      for (int c = 0; c < 600; c++) begin
         rv_sel = 1'($urandom);
         rv_a = 8'($urandom); rv_b = 8'($urandom);
         rv_m = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'hFF;
         if ($urandom_range(0, 5) == 0) rv_m = 8'h00;
         drive(rv_sel, rv_a, rv_b, rv_m);
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 2) != 0);
         #1;
         exp_rdy = (q.size() < DEPTH) || (q.size() > 0 && out_ready);
         chk("rnd_valid", 64'(out_valid), 64'(q.size() > 0));
         chk("rnd_occ",   64'(occupancy), 64'(q.size()));
         chk("rnd_ready", 64'(in_ready),  64'(exp_rdy));
         if (q.size() > 0)
            chk("rnd_head", {39'(0), out_any, out_idx, out_grant, out_vec},
                {39'(0), q[0].any, q[0].idx, q[0].grant, q[0].vec});
         push = in_valid && exp_rdy;
         pop  = (q.size() > 0) && out_ready;
         r = model(rv_sel, rv_a, rv_b, rv_m, mrp);
         @(posedge clk);
         if (pop) void'(q.pop_front());
         if (push) begin
            q.push_back(r);
            model_accept(r);
         end
         #1;
      end
      in_valid = 1'b0; out_ready = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/prio_sel_pipe.md
Name: prio_sel_pipe

Overview:
- Parametrised, pipelined successor to the combinational lane-select/priority logic in the lgsynth-style control blocks.
- Per accepted beat, it performs two operations:
  - Bitwise select between two W-bit sources.
  - Lowest-index priority encode of the selected vector, producing a one-hot grant and a binary index.
- Results are queued in a DEPTH-entry output FIFO with valid/ready handshakes on both sides.
- Sits between the decode front end and the lane-enable consumers.

Parameters:
- W, 8, data/lane width; legal range 2..64.
- DEPTH, 2, output FIFO entries; power of two, 2..16.
- IW, $clog2(W), index width; derived, not overridable.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  input beat valid
- in_ready  out  1  input beat accepted when in_valid & in_ready
- in_a  in  W  source A
- in_b  in  W  source B
- in_sel  in  1  0 selects A, 1 selects B
- in_mask  in  W  lane mask; a lane participates only if its mask bit is 1
- out_valid  out  1  FIFO head valid
- out_ready  in  1  consumer ready
- out_vec  out  W  selected vector: (in_sel ? in_b : in_a) & in_mask
- out_grant  out  W  one-hot grant, or zero if none
- out_idx  out  IW  index of the granted lane, or 0 if none
- out_any  out  1  1 if any lane is granted
- occupancy  out  $clog2(DEPTH)+1  current FIFO fill

Behaviour:
- Reset (synchronous, rst=1 at a rising edge):
  - FIFO is emptied; out_valid=0, occupancy=0.
  - out_vec, out_grant, out_idx and out_any all read 0.
  - in_ready=1 from the first cycle after reset.
  - Any beat presented during a reset cycle is discarded.
  - The rotate pointer (feature on) returns to 0.
- Stage 0 (combinational on inputs):
  - Compute sel_vec = (in_sel ? in_b : in_a) & in_mask.
  - Grant the lowest set bit of sel_vec; idx is its binary position.
  - If sel_vec==0: grant=0, idx=0, any=0.
- Accept: a beat is accepted on a cycle where in_valid & in_ready.
  - Its stage-0 result is written to the FIFO tail at that edge.
  - Latency is 1: an accept into an empty FIFO gives out_valid=1 on the next cycle with that beat at the head.
- Pop: occurs on out_valid & out_ready; the head advances at the edge.
- in_ready = (occupancy < DEPTH) | (out_valid & out_ready).
  - A full FIFO still accepts in the same cycle it pops; this is a registered-pointer FIFO with same-cycle push and pop allowed.
- Simultaneous push and pop on an empty FIFO cannot occur, since out_valid=0. The push still lands and occupancy becomes 1.
- Push and pop together on a non-empty FIFO leave occupancy unchanged.
- Ordering: strict FIFO. No beat is dropped or duplicated.
- Pointers wrap modulo DEPTH. Full/empty are distinguished by the extra occupancy bit.
- Outputs are driven from FIFO storage only; there are no combinational paths from inputs to out_*.
- in_ready depends combinationally on out_ready only.
- When out_valid=0, out_* data reads 0 (masked), not stale contents.

Optional Feature:
- PRIO_SEL_ROTATE_EN
- Defined:
  - Adds a registered rotate pointer rp (IW bits, reset 0).
  - Priority search starts at lane rp and wraps upward: rp, rp+1, ..., W-1, 0, ..., rp-1.
  - On each accepted beat with any=1, rp becomes (granted idx + 1) mod W.
  - Beats with any=0 leave rp unchanged.
  - This gives round-robin fairness across beats.
- Undefined:
  - No rp register exists; fixed lowest-index priority applies.
  - Port list is identical in both builds.

Test Plan:
- Reset, then push A=8'h00, B=8'h30, sel=1, mask=8'hFF → next cycle out_vec=8'h30, out_grant=8'h10, out_idx=4, out_any=1.
- sel=0, A=8'hA0, mask=8'h7F → out_vec=8'h20, out_grant=8'h20, out_idx=5; with mask=8'h00 → out_any=0, out_grant=0, out_idx=0.
- DEPTH=2, out_ready=0, push 3 beats:
  - Expected: first two accepted, occupancy=2, in_ready=0 on the third.
  - Then raise out_ready with in_valid held: pop and push occur the same cycle and occupancy stays 2.
  - Drained order matches push order.
- Fill to 1 entry, assert rst for one cycle with in_valid=1 → out_valid=0, occupancy=0 next cycle, the presented beat is not stored, and in_ready=1.
- PRIO_SEL_ROTATE_EN, W=8, mask=8'hFF, vector 8'h11 pushed four times:
  - Expected grant sequence: 8'h01, 8'h10, 8'h01, 8'h10.
  - Then a beat with vector 8'h00 leaves rp unchanged, so the next 8'h11 grants 8'h01.
- Feature off, same stimulus → grants 8'h01 every beat.
